pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RV32I pipeline (IF, ID, EX, MEM, WB).
- Merges load-use stall requests from the rs1/rs2 forwarding units, the EX-stage redirect, and instruction/data memory wait.
- Drives the PC write enable and the per-stage pipeline-register enables and flushes.
- Owns a small FSM for data-memory wait, timeout and halt, plus saturating performance counters for stalls and flushes.

Parameters:
WAIT_MAX, 16, dmem wait cycles tolerated before a bus error (1..255).
CNT_W, 32, width of the performance counters.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
load_stall_rs1  in  1  load-use hazard on rs1 (forwarding unit LoadStall)
load_stall_rs2  in  1  load-use hazard on rs2 (forwarding unit LoadStall)
ex_redirect  in  1  taken branch / JAL / JALR resolved in EX
imem_ready  in  1  instruction fetch data valid this cycle
dmem_req  in  1  MEM stage holds a Load/Store this cycle
dmem_ready  in  1  data memory completes the access this cycle
halt_req  in  1  ECALL/EBREAK reached WB
pc_en  out  1  PC register load enable
if_id_en  out  1  IF/ID register enable
id_ex_en  out  1  ID/EX register enable
ex_mem_en  out  1  EX/MEM register enable
mem_wb_en  out  1  MEM/WB register enable
if_id_flush  out  1  load NOP into IF/ID (effective only when if_id_en=1)
id_ex_flush  out  1  load NOP into ID/EX (effective only when id_ex_en=1)
halted  out  1  core halted (state HALTED)
bus_err  out  1  one-cycle pulse on dmem timeout
stall_cnt  out  CNT_W  load-use stall cycles, saturating
flush_cnt  out  CNT_W  redirect events, saturating

Behaviour:
Reset and state:
- One clock (clk); reset rst is synchronous and active-high.
- FSM states: RUN, MWAIT, HALTED. The state register, wait counter (8 bit), bus_err register and both perf counters are clocked.
- The enables and flushes are combinational from state and inputs.
- While rst=1: all *_en=0, if_id_flush=1, id_ex_flush=1, halted=0, bus_err=0. Next state is RUN; wait counter and both perf counters clear to 0.

Decision priority (RUN, or MWAIT with dmem_ready=1), first match wins:
1. halt_req=1: all *_en=0; next HALTED.
2. dmem_req=1 and dmem_ready=0 (RUN only): all *_en=0, no flush; next MWAIT; wait counter is set to 1.
3. ex_redirect=1: all *_en=1, if_id_flush=1, id_ex_flush=1. Load-stall requests are ignored (they belong to the wrong path). flush_cnt+1.
4. load_stall_rs1 or load_stall_rs2: pc_en=0, if_id_en=0, id_ex_en=1 with id_ex_flush=1 (bubble), ex_mem_en=1, mem_wb_en=1. stall_cnt+1 (one count per cycle, even if both requests are set).
5. imem_ready=0: pc_en=0, if_id_en=1 with if_id_flush=1; the rest are 1.
6. Otherwise: all *_en=1, no flush.

MWAIT:
- dmem_ready=0: all *_en=0 and the wait counter increments.
- If the counter equals WAIT_MAX while dmem_ready=0: bus_err=1 for exactly the next cycle; next HALTED.
- dmem_ready=1: evaluate rules 1 and 3–6 in the same cycle; next RUN; wait counter clears.

HALTED:
- All *_en=0, halted=1, no flushes. Inputs are ignored; only rst leaves this state.

Counters:
- Both counters saturate at 2^CNT_W-1; they never wrap.
- Counters are frozen in MWAIT (while not ready) and in HALTED.

Other rules:
- An enable is never asserted while the stage downstream of it is frozen: ex_mem_en=0 implies id_ex_en=0, if_id_en=0 and pc_en=0.
- Reset asserted mid-MWAIT or in HALTED returns to RUN on the next edge with no bus_err pulse.

Decomposition:
- Shared package rv32i_pkg holds the opcode constants (RR, JAL, Branch, Load, Store, Imm, LUI, AUIPC, JALR) and the FSM state encoding: RUN=2'd0, MWAIT=2'd1, HALTED=2'd2.
- Natural sub-module: sat_counter, parameterised by CNT_W with inc and clear inputs, instantiated twice.

Test Plan:
1. Load-use stall: load_stall_rs1=1 for one cycle in RUN. Required: pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=1, stall_cnt 0→1. Next cycle all *_en=1.
2. Redirect beats stall: ex_redirect=1 and load_stall_rs2=1 together. Required: all *_en=1, if_id_flush=1, id_ex_flush=1, flush_cnt=1, stall_cnt=0.
3. Dmem wait: dmem_req=1, dmem_ready=0 for 3 cycles, then 1. Required: all *_en=0 for 3 cycles, state MWAIT. In the ready cycle, all *_en=1 and the next state is RUN.
4. Timeout: WAIT_MAX=4, dmem_ready held 0. Required: bus_err high for exactly one cycle, then halted=1 and all *_en=0 indefinitely. rst=1 for one cycle returns to RUN with halted=0.
5. Fetch miss: imem_ready=0 with no other request. Required: pc_en=0, if_id_en=1, if_id_flush=1, id_ex_en=1.
6. Saturation: CNT_W=4 with 20 load-stall cycles. Required: stall_cnt stops at 15. rst clears it to 0.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: base opcodes, hazard-controller FSM state
// encoding and the packed pipeline-control payload.
package rv32i_pkg;

  localparam int unsigned OPC_W = 7;

  // RV32I major opcodes
  localparam logic [OPC_W-1:0] OPC_RR     = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_IMM    = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;

  localparam int unsigned WAIT_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_MWAIT  = 2'd1,
    ST_HALTED = 2'd2
  } hz_state_e;

  // Per-cycle pipeline control word
  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
  } pipe_ctrl_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: hazard/memory requests from the pipeline and
// the enables, flushes, status and perf counters returned to it.
//   master : pipeline side (drives requests, consumes controls)
//   slave  : hazard controller
interface pipe_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic             load_stall_rs1;
  logic             load_stall_rs2;
  logic             ex_redirect;
  logic             imem_ready;
  logic             dmem_req;
  logic             dmem_ready;
  logic             halt_req;
  logic             pc_en;
  logic             if_id_en;
  logic             id_ex_en;
  logic             ex_mem_en;
  logic             mem_wb_en;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             halted;
  logic             bus_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output load_stall_rs1, load_stall_rs2, ex_redirect, imem_ready,
           dmem_req, dmem_ready, halt_req,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, halted, bus_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  load_stall_rs1, load_stall_rs2, ex_redirect, imem_ready,
           dmem_req, dmem_ready, halt_req,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, halted, bus_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk    : clock, rising edge
//   clr_i  : synchronous clear (wins over inc_i)
//   inc_i  : count one event this cycle
//   cnt_o  : current count, sticks at all-ones
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline. Merges load-use,
// redirect, fetch-miss and data-memory-wait conditions into PC/stage enables
// and flushes; tracks dmem wait timeout and halt; counts stalls and flushes.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : pipe_hazard_ctrl_if slave (requests in, enables/flushes/status out)
module pipe_hazard_ctrl
  import rv32i_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 16,
  parameter int unsigned CNT_W    = 32
) (
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_ctrl_if.slave  bus
);

  hz_state_e              state_q, state_d;
  logic [WAIT_CNT_W-1:0]  wait_q, wait_d;
  logic                   bus_err_q, bus_err_d;
  pipe_ctrl_t             ctrl_c;
  logic                   stall_inc_c;
  logic                   flush_inc_c;

  // State, wait counter and bus-error pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      wait_q    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Next-state and pipeline control decode
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    bus_err_d   = 1'b0;
    ctrl_c      = '0;
    stall_inc_c = 1'b0;
    flush_inc_c = 1'b0;

    if (rst) begin
      ctrl_c.if_id_flush = 1'b1;
      ctrl_c.id_ex_flush = 1'b1;
      state_d            = ST_RUN;
      wait_d             = '0;
    end else if (state_q == ST_HALTED) begin
      // everything frozen until reset
    end else if ((state_q == ST_MWAIT) && !bus.dmem_ready) begin
      if (wait_q == WAIT_CNT_W'(WAIT_MAX)) begin
        bus_err_d = 1'b1;
        state_d   = ST_HALTED;
      end else begin
        wait_d = wait_q + WAIT_CNT_W'(1);
      end
    end else begin
      // RUN, or MWAIT completing this cycle (rule 2 cannot re-fire there)
      if (state_q != ST_RUN) begin
        state_d = ST_RUN;
        wait_d  = '0;
      end

      if (bus.halt_req) begin
        state_d = ST_HALTED;
      end else if ((state_q == ST_RUN) && bus.dmem_req && !bus.dmem_ready) begin
        state_d = ST_MWAIT;
        wait_d  = WAIT_CNT_W'(1);
      end else if (bus.ex_redirect) begin
        // wrong-path load-use requests are dropped
        ctrl_c      = '1;
        flush_inc_c = 1'b1;
      end else if (bus.load_stall_rs1 || bus.load_stall_rs2) begin
        ctrl_c.id_ex_en    = 1'b1;
        ctrl_c.id_ex_flush = 1'b1;
        ctrl_c.ex_mem_en   = 1'b1;
        ctrl_c.mem_wb_en   = 1'b1;
        stall_inc_c        = 1'b1;
      end else if (!bus.imem_ready) begin
        ctrl_c.if_id_en    = 1'b1;
        ctrl_c.if_id_flush = 1'b1;
        ctrl_c.id_ex_en    = 1'b1;
        ctrl_c.ex_mem_en   = 1'b1;
        ctrl_c.mem_wb_en   = 1'b1;
      end else begin
        ctrl_c.pc_en     = 1'b1;
        ctrl_c.if_id_en  = 1'b1;
        ctrl_c.id_ex_en  = 1'b1;
        ctrl_c.ex_mem_en = 1'b1;
        ctrl_c.mem_wb_en = 1'b1;
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr_i (rst),
    .inc_i (stall_inc_c),
    .cnt_o (bus.stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clr_i (rst),
    .inc_i (flush_inc_c),
    .cnt_o (bus.flush_cnt)
  );

  assign bus.pc_en       = ctrl_c.pc_en;
  assign bus.if_id_en    = ctrl_c.if_id_en;
  assign bus.id_ex_en    = ctrl_c.id_ex_en;
  assign bus.ex_mem_en   = ctrl_c.ex_mem_en;
  assign bus.mem_wb_en   = ctrl_c.mem_wb_en;
  assign bus.if_id_flush = ctrl_c.if_id_flush;
  assign bus.id_ex_flush = ctrl_c.id_ex_flush;
  // Status is masked while reset is held, before the registers clear
  assign bus.halted      = (state_q == ST_HALTED) && !rst;
  assign bus.bus_err     = bus_err_q && !rst;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  localparam int unsigned WAIT_MAX = 4;
  localparam int unsigned CNT_W    = 4;
  localparam int          CNT_MAX  = (1 << CNT_W) - 1;

  // Expected control words, bit order {pc,if_id,id_ex,ex_mem,mem_wb,if_id_flush,id_ex_flush}
  localparam logic [6:0] V_FREEZE   = 7'b0000000;
  localparam logic [6:0] V_RESET    = 7'b0000011;
  localparam logic [6:0] V_NORMAL   = 7'b1111100;
  localparam logic [6:0] V_REDIRECT = 7'b1111111;
  localparam logic [6:0] V_BUBBLE   = 7'b0011101;
  localparam logic [6:0] V_FETCH    = 7'b0111110;

  logic clk = 1'b0;
  logic rst;

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

  pipe_hazard_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (hz)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: 0 = running, 1 = waiting on data memory, 2 = halted
  int m_mode   = 0;
  int m_wait   = 0;
  int m_stall  = 0;
  int m_flush  = 0;
  bit m_buserr = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, compare against the model, clock it, advance model
  task automatic step(input string tag, input bit r, input bit ls1, input bit ls2,
                      input bit redir, input bit imem, input bit req, input bit rdy,
                      input bit halt);
    logic [6:0] e;
    logic [6:0] obs;
    int  n_mode, n_wait;
    bit  n_err, s_inc, f_inc;

    rst               = r;
    hz.load_stall_rs1 = ls1;
    hz.load_stall_rs2 = ls2;
    hz.ex_redirect    = redir;
    hz.imem_ready     = imem;
    hz.dmem_req       = req;
    hz.dmem_ready     = rdy;
    hz.halt_req       = halt;
    #1;

    e = V_FREEZE; n_mode = m_mode; n_wait = m_wait; n_err = 0; s_inc = 0; f_inc = 0;
    if (r) begin
      e = V_RESET; n_mode = 0; n_wait = 0;
    end else if (m_mode == 2) begin
      e = V_FREEZE;
    end else if (m_mode == 1 && !rdy) begin
      if (m_wait == int'(WAIT_MAX)) begin n_err = 1; n_mode = 2; end
      else n_wait = m_wait + 1;
    end else begin
      n_mode = 0; n_wait = 0;
      if (halt) n_mode = 2;
      else if (m_mode == 0 && req && !rdy) begin n_mode = 1; n_wait = 1; end
      else if (redir) begin e = V_REDIRECT; f_inc = 1; end
      else if (ls1 || ls2) begin e = V_BUBBLE; s_inc = 1; end
      else if (!imem) e = V_FETCH;
      else e = V_NORMAL;
    end

    obs = {hz.pc_en, hz.if_id_en, hz.id_ex_en, hz.ex_mem_en, hz.mem_wb_en,
           hz.if_id_flush, hz.id_ex_flush};
    chk({tag, ".ctrl"},    32'(obs), 32'(e));
    chk({tag, ".halted"},  32'(hz.halted), 32'((m_mode == 2) && !r));
    chk({tag, ".bus_err"}, 32'(hz.bus_err), 32'(m_buserr && !r));
    chk({tag, ".stall"},   32'(hz.stall_cnt), 32'(m_stall));
    chk({tag, ".flush"},   32'(hz.flush_cnt), 32'(m_flush));

    @(posedge clk);
    if (r) begin
      m_stall = 0; m_flush = 0; m_buserr = 0;
    end else begin
      if (s_inc && m_stall < CNT_MAX) m_stall++;
      if (f_inc && m_flush < CNT_MAX) m_flush++;
      m_buserr = n_err;
    end
    m_mode = n_mode;
    m_wait = n_wait;
    #1;
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 0, 0, 0, 0, 1, 0, 1, 0);
  endtask

  initial begin
    // Bring the DUT out of X before the model takes over
    rst = 1'b1;
    hz.load_stall_rs1 = 0; hz.load_stall_rs2 = 0; hz.ex_redirect = 0;
    hz.imem_ready = 1; hz.dmem_req = 0; hz.dmem_ready = 1; hz.halt_req = 0;
    @(posedge clk); #1;

    step("reset", 1, 0, 0, 0, 1, 0, 1, 0);
    idle("idle0", 2);

    // Load-use stall, then free-running
    step("ldstall", 0, 1, 0, 0, 1, 0, 1, 0);
    idle("post_stall", 1);

    // Redirect outranks a simultaneous stall
    step("redir_vs_stall", 0, 0, 1, 1, 1, 0, 1, 0);
    idle("post_redir", 1);

    // Dmem wait for 3 cycles, then ready
    for (int i = 0; i < 3; i++) step("mwait", 0, 0, 0, 0, 1, 1, 0, 0);
    step("mwait_ready", 0, 0, 0, 0, 1, 1, 1, 0);
    idle("post_mwait", 1);

    // Ready cycle of a wait that also carries a stall request
    step("mwait2", 0, 0, 0, 0, 1, 1, 0, 0);
    step("mwait2_rdy_stall", 0, 1, 1, 0, 1, 1, 1, 0);

    // Fetch miss
    step("fetch_miss", 0, 0, 0, 0, 0, 0, 1, 0);
    idle("post_fetch", 1);

    // Counter saturation, then reset clears
    for (int i = 0; i < 20; i++) step("sat", 0, i[0], ~i[0], 0, 1, 0, 1, 0);
    for (int i = 0; i < 18; i++) step("sat_flush", 0, 0, 0, 1, 1, 0, 1, 0);
    step("sat_rst", 1, 0, 0, 0, 1, 0, 1, 0);
    idle("post_sat", 1);

    // Timeout into halt, inputs ignored, reset recovers
    for (int i = 0; i < 10; i++) step("timeout", 0, 1, 0, 1, 0, 1, 0, 0);
    step("halt_ign", 0, 0, 0, 0, 1, 1, 1, 1);
    step("halt_rst", 1, 0, 0, 0, 1, 0, 1, 0);
    idle("post_halt", 2);

    // Reset mid-wait exactly at the timeout boundary: no bus_err pulse
    for (int i = 0; i < int'(WAIT_MAX) + 1; i++) step("wait_rst_pre", 0, 0, 0, 0, 1, 1, 0, 0);
    step("wait_rst", 1, 0, 0, 0, 1, 1, 0, 0);
    idle("post_wait_rst", 2);

    // Explicit halt request, then reset
    step("halt_req", 0, 1, 0, 1, 0, 1, 0, 1);
    step("halted", 0, 0, 0, 0, 1, 0, 1, 0);
    step("halt_rst2", 1, 0, 0, 0, 1, 0, 1, 0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit r, ls1, ls2, redir, imem, req, rdy, halt;
      r     = ($urandom_range(0, 99) == 0) || (m_mode == 2 && $urandom_range(0, 3) == 0);
      ls1   = ($urandom_range(0, 3) == 0);
      ls2   = ($urandom_range(0, 3) == 0);
      redir = ($urandom_range(0, 5) == 0);
      imem  = ($urandom_range(0, 4) != 0);
      req   = ($urandom_range(0, 2) == 0);
      rdy   = (m_mode == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 0);
      halt  = ($urandom_range(0, 79) == 0);
      step("rand", r, ls1, ls2, redir, imem, req, rdy, halt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
